vga_sync_generator: RTL and testbench
=====================================

Name: vga_sync_generator

Overview:
- Pixel-timing stage directly downstream of the game clock generator. Runs on the 25 MHz vga_clk.
- Produces hsync/vsync, active-video flag and pixel coordinates for the sprite/renderer logic.
- Produces frame_start and vblank_start strobes so game logic can latch state once per frame.
- Default timing: 640x480 @ 60 Hz, 800x525 total.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
FCNT_W, 16, frame counter width

Ports:
vga_clk  input  1  pixel clock, 25 MHz; all logic on its rising edge
reset  input  1  synchronous, active-high reset
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  high inside the visible region
pixel_x  output  HW  horizontal counter value; HW = $clog2(H_TOTAL), 10 by default
pixel_y  output  VW  vertical counter value; VW = $clog2(V_TOTAL), 10 by default
frame_start  output  1  one-cycle pulse at (x=0, y=0)
vblank_start  output  1  one-cycle pulse at (x=0, y=V_ACTIVE)
frame_count  output  FCNT_W  completed-frame count, wraps modulo 2^FCNT_W

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters:
  - h_cnt counts 0..H_TOTAL-1 every cycle and wraps to 0.
  - v_cnt increments only when h_cnt wraps; it wraps 0..V_TOTAL-1.
- All outputs are registered. Each output reflects the counter state of the previous cycle (1-cycle latency).
- Output decodes from (h_cnt, v_cnt):
  - hsync asserted iff H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491), for the whole line.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pixel_x = h_cnt and pixel_y = v_cnt at all times, not gated. Consumers qualify with video_on.
  - frame_start = (h_cnt==0 && v_cnt==0).
  - vblank_start = (h_cnt==0 && v_cnt==V_ACTIVE).
  - frame_count increments when h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1; wraps silently.
- Reset values (the cycle after reset is sampled high):
  - h_cnt = v_cnt = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - video_on = 0; pixel_x = pixel_y = 0.
  - frame_start = vblank_start = 0; frame_count = 0.
- First cycle after reset release: counters go to h=1 and outputs show the (0,0) state, i.e. video_on=1 and frame_start=1.
- Reset mid-frame: reset dominates any wrap or increment in the same cycle. Counting restarts from (0,0), with no partial strobes.
- No clock enable: vga_clk is already the divided pixel clock.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (H_*/V_*);
  - derived H_TOTAL/V_TOTAL;
  - SYNC start/end localparams;
  - width helpers.
- One sub-module, mod_counter (parameters MODULUS, W; inputs clk, reset, inc; outputs count, wrap with wrap = inc && count==MODULUS-1). Instantiate twice:
  - h: inc = 1;
  - v: inc = h.wrap.

Test Plan:
- Reset values: hold reset 5 cycles -> during reset and on the first output cycle: hsync=vsync=1, video_on=0, pixel_x=pixel_y=0, frame_count=0. Next cycle: video_on=1, frame_start=1.
- Line timing:
  - hsync low for exactly 96 consecutive cycles, starting 656 cycles after each frame_start/line start;
  - hsync period 800 cycles;
  - video_on high 640 cycles per visible line.
- Frame timing:
  - vsync low exactly 1600 cycles, starting at line 490;
  - frame_start period 420000 cycles;
  - vblank_start exactly 480*800 = 384000 cycles after frame_start;
  - video_on high 307200 cycles per frame.
- Frame counter: run 3 frames -> frame_count 0→1→2→3, each step one cycle after x=799, y=524. With FCNT_W=2, frames 4 and 5 read 0 and 1.
- Reset mid-operation: assert reset at pixel (300,100) for 1 cycle -> next cycle all outputs equal reset values, then the sequence restarts at (0,0) with frame_start=1, and no vblank_start or frame_count change occurs.
- Small-parameter run with H 8/2/2/2, V 4/1/1/1, SYNC_POL=1:
  - hsync high for cycles 10..11 of each 14-cycle line;
  - vsync high for line 5 of each 7-line frame;
  - frame_start period 98 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and width/bound helpers
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction
endpackage

// File: rtl/vga_sync_generator_mod_counter.sv
// rtl/vga_sync_generator_mod_counter.sv - modulo-N counter with wrap strobe
module mod_counter #(
  parameter int MODULUS = 800,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - raster counters and registered sync/blank/strobe decode
module vga_sync_generator import vga_timing_pkg::*; #(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   FCNT_W   = 16,
  localparam int  H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  HW       = cnt_width(H_TOTAL),
  localparam int  VW       = cnt_width(V_TOTAL)
) (
  input  logic              vga_clk,
  input  logic              reset,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [HW-1:0]     pixel_x,
  output logic [VW-1:0]     pixel_y,
  output logic              frame_start,
  output logic              vblank_start,
  output logic [FCNT_W-1:0] frame_count
);
  localparam logic [HW-1:0] HS_START = HW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [HW-1:0] HS_END   = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [VW-1:0] VS_START = VW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [VW-1:0] VS_END   = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  mod_counter #(.MODULUS(H_TOTAL), .W(HW)) u_h_cnt (
    .clk(vga_clk), .reset(reset), .inc(1'b1), .count(h_cnt), .wrap(h_wrap)
  );

  mod_counter #(.MODULUS(V_TOTAL), .W(VW)) u_v_cnt (
    .clk(vga_clk), .reset(reset), .inc(h_wrap), .count(v_cnt), .wrap(v_wrap)
  );

  // v_wrap is only true on the last pixel of the last line, i.e. the frame end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_on     <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      hsync        <= (h_cnt >= HS_START && h_cnt <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync        <= (v_cnt >= VS_START && v_cnt <= VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on     <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      pixel_x      <= h_cnt;
      pixel_y      <= v_cnt;
      frame_start  <= (h_cnt == '0) && (v_cnt == '0);
      vblank_start <= (h_cnt == '0) && (v_cnt == V_VIS);
      if (v_wrap)
        frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - directed checks of default and reduced-size raster timing
module tb_vga_sync_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst, d_hs, d_vs, d_von, d_fs, d_vb;
  logic [9:0]  d_px, d_py;
  logic [15:0] d_fc;

  logic        s_rst, s_hs, s_vs, s_von, s_fs, s_vb;
  logic [3:0]  s_px;
  logic [2:0]  s_py;
  logic [1:0]  s_fc;

  int checks = 0;
  int errors = 0;

  vga_sync_generator u_def (
    .vga_clk(clk), .reset(d_rst), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pixel_x(d_px), .pixel_y(d_py), .frame_start(d_fs), .vblank_start(d_vb),
    .frame_count(d_fc)
  );

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FCNT_W(2)
  ) u_small (
    .vga_clk(clk), .reset(s_rst), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pixel_x(s_px), .pixel_y(s_py), .frame_start(s_fs), .vblank_start(s_vb),
    .frame_count(s_fc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int fall1, fall2, low_run, low_len, von_cnt, fs_cnt, vb_cnt, vs_low;
    logic prev_hs;
    int ex, ey;
    bit found;

    d_rst = 1'b1;
    s_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_hsync", d_hs, 1);
      chk("rst_vsync", d_vs, 1);
      chk("rst_video_on", d_von, 0);
      chk("rst_pixel_x", d_px, 0);
      chk("rst_pixel_y", d_py, 0);
      chk("rst_frame_start", d_fs, 0);
      chk("rst_frame_count", d_fc, 0);
    end

    d_rst = 1'b0;
    step();
    chk("first_video_on", d_von, 1);
    chk("first_frame_start", d_fs, 1);
    chk("first_pixel_x", d_px, 0);
    chk("first_pixel_y", d_py, 0);
    chk("first_hsync", d_hs, 1);

    fall1 = -1; fall2 = -1; low_run = 0; low_len = -1;
    von_cnt = 0; fs_cnt = 0; vb_cnt = 0; vs_low = 0; prev_hs = 1'b1;
    for (int t = 0; t < 1600; t++) begin
      if (prev_hs && !d_hs) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      if (!d_hs) low_run++;
      else if (low_run > 0 && low_len < 0) low_len = low_run;
      if (t < 800 && d_von) von_cnt++;
      if (d_fs) fs_cnt++;
      if (d_vb) vb_cnt++;
      if (!d_vs) vs_low++;
      if (t == 799) begin
        chk("line_end_x", d_px, 799);
        chk("line_end_y", d_py, 0);
      end
      if (t == 800) begin
        chk("line1_x", d_px, 0);
        chk("line1_y", d_py, 1);
      end
      prev_hs = d_hs;
      step();
    end
    chk("hsync_start", fall1, 656);
    chk("hsync_period_next", fall2, 1456);
    chk("hsync_low_len", low_len, 96);
    chk("video_on_per_line", von_cnt, 640);
    chk("frame_start_count", fs_cnt, 1);
    chk("vblank_count", vb_cnt, 0);
    chk("vsync_low_early", vs_low, 0);

    s_rst = 1'b0;
    step();
    for (int t = 0; t < 588; t++) begin
      ex = t % 14;
      ey = (t / 14) % 7;
      chk("s_pixel_x", s_px, ex);
      chk("s_pixel_y", s_py, ey);
      chk("s_hsync", s_hs, (ex >= 10 && ex <= 11) ? 1 : 0);
      chk("s_vsync", s_vs, (ey == 5) ? 1 : 0);
      chk("s_video_on", s_von, (ex < 8 && ey < 4) ? 1 : 0);
      chk("s_frame_start", s_fs, (t % 98 == 0) ? 1 : 0);
      chk("s_vblank_start", s_vb, (t % 98 == 56) ? 1 : 0);
      chk("s_frame_count", s_fc, ((t + 1) / 98) % 4);
      step();
    end

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (s_px == 4'd3 && s_py == 3'd2) found = 1'b1;
      else step();
    end
    chk("s_reach_3_2", found, 1);

    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("mid_rst_hsync", s_hs, 0);
    chk("mid_rst_vsync", s_vs, 0);
    chk("mid_rst_video_on", s_von, 0);
    chk("mid_rst_pixel_x", s_px, 0);
    chk("mid_rst_pixel_y", s_py, 0);
    chk("mid_rst_frame_start", s_fs, 0);
    chk("mid_rst_vblank", s_vb, 0);
    chk("mid_rst_frame_count", s_fc, 0);
    step();
    chk("restart_frame_start", s_fs, 1);
    chk("restart_pixel_x", s_px, 0);
    chk("restart_pixel_y", s_py, 0);
    chk("restart_video_on", s_von, 1);
    for (int k = 1; k <= 56; k++) begin
      step();
      chk("restart_vblank", s_vb, (k == 56) ? 1 : 0);
      chk("restart_frame_count", s_fc, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
